// File: rtl/mem_pkg.sv
// Shared memory-interface constants, fetch FSM states and the fetch buffer entry layout.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    // Memory bus direction encoding.
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Default memory window: 1 MiB starting at 0x0100_0000.
    localparam logic [XLEN-1:0] STARTING_ADDR_DEFAULT   = 32'h0100_0000;
    localparam logic [XLEN-1:0] MEM_DEPTH_BYTES_DEFAULT = 32'h0010_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    // One 64-bit buffer entry: the fetched word and the byte address it came from.
    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO of fetched {insn, pc} pairs; the head always sits in e0_q so the
// head outputs come straight from a register.
// Ports:
//   clock, reset      - clock and synchronous active-high reset (contents cleared to 0)
//   push_i, entry_i   - write a new entry at the tail
//   pop_i             - discard the head
//   flush_i           - empty the FIFO (wins over push/pop)
//   head_o            - current head entry
//   full_o, empty_o   - occupancy flags
module fetch_fifo
    import mem_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t e0_q;
    fetch_entry_t e1_q;
    logic [1:0]   count_q;
    logic         do_pop_c;
    logic         do_push_c;

    // Guard against popping empty or pushing into a full FIFO without a matching pop.
    assign do_pop_c  = pop_i && (count_q != 2'd0);
    assign do_push_c = push_i && ((count_q != 2'd2) || do_pop_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_q + 2'(do_push_c) - 2'(do_pop_c);
            if (do_pop_c) begin
                e0_q <= e1_q;
            end
            // New entry lands in the first slot that is free after this cycle's pop.
            if (do_push_c) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && do_pop_c)) begin
                    e0_q <= entry_i;
                end else begin
                    e1_q <= entry_i;
                end
            end
        end
    end

    assign head_o  = e0_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: reads one word per cycle from a combinational memory,
// buffers up to two words, supports pc redirects and faults sticky on misalignment or
// leaving the memory window.
// Ports:
//   clock, reset                   - clock and synchronous active-high reset
//   address, data_in, read_write   - memory request (address = pc, always a read)
//   data_out                       - memory read data for address
//   redirect_valid, redirect_pc    - one-cycle request to restart fetch at a new pc
//   insn_valid, insn_ready         - head handshake
//   insn, insn_pc                  - head instruction word and its byte address
//   fault                          - sticky fetch error, cleared only by reset
//   fetch_count                    - words pushed since reset (wrapping)
module fetch_unit
    import mem_pkg::*;
#(
    parameter logic [XLEN-1:0] STARTING_ADDR   = STARTING_ADDR_DEFAULT,
    parameter logic [XLEN-1:0] MEM_DEPTH_BYTES = MEM_DEPTH_BYTES_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] data_out,
    output logic            read_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            insn_valid,
    input  logic            insn_ready,
    output logic [XLEN-1:0] insn,
    output logic [XLEN-1:0] insn_pc,
    output logic            fault,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [XLEN-1:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fetch_count_q;
    logic            fault_q;

    fetch_entry_t    head;
    fetch_entry_t    new_entry;
    logic            fifo_full;
    logic            fifo_empty;

    logic            in_range_c;
    logic            pop_req_c;
    logic            slot_c;
    logic            push_c;
    logic            pop_c;
    logic            flush_c;
    logic            redirect_c;
    logic            range_fault_c;

    assign in_range_c = (pc_q >= STARTING_ADDR) && (pc_q <= LAST_ADDR);
    assign pop_req_c  = !fifo_empty && insn_ready;
    // A fetch slot exists when there is room now or the head leaves this cycle.
    assign slot_c     = !fifo_full || pop_req_c;

    // Per-cycle buffer control; redirect beats a range fault, which beats push/pop.
    always_comb begin
        push_c        = 1'b0;
        pop_c         = 1'b0;
        flush_c       = 1'b0;
        redirect_c    = 1'b0;
        range_fault_c = 1'b0;
        if (state_q == ST_RUN) begin
            if (redirect_valid) begin
                redirect_c = 1'b1;
                flush_c    = 1'b1;
            end else if (slot_c && !in_range_c) begin
                range_fault_c = 1'b1;
                flush_c       = 1'b1;
            end else begin
                push_c = slot_c;
                pop_c  = pop_req_c;
            end
        end else begin
            flush_c = 1'b1;
        end
    end

    // Fetch FSM with pc, counter and fault flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= STARTING_ADDR;
            fetch_count_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_c) begin
                        pc_q <= redirect_pc;
                        if (redirect_pc[1:0] != 2'b00) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (range_fault_c) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (push_c) begin
                        pc_q          <= pc_q + 32'd4;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    assign new_entry = '{insn: data_out, pc: pc_q};

    fetch_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (flush_c),
        .entry_i (new_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign address     = pc_q;
    assign data_in     = '0;
    assign read_write  = READ;
    assign insn_valid  = !fifo_empty;
    assign insn        = head.insn;
    assign insn_pc     = head.pc;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] DEPTH = 32'h0010_0000;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_fault;
    bit          m_clean;   // no push since reset: head fields must still read 0
    logic [63:0] m_q[$];    // {insn, pc}, front is the head

    fetch_unit #(
        .STARTING_ADDR   (START),
        .MEM_DEPTH_BYTES (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .data_in        (data_in),
        .data_out       (data_out),
        .read_write     (read_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign data_out = mem_word(address);

    function automatic bit legal(input logic [31:0] pc);
        logic [63:0] p;
        p = {32'd0, pc};
        return (p >= {32'd0, START}) && (p + 64'd4 <= {32'd0, START} + {32'd0, DEPTH});
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model one clock edge using the inputs currently driven.
    task automatic model_step();
        bit popped;
        bit slot;
        if (reset) begin
            m_pc = START; m_cnt = 0; m_fault = 0; m_clean = 1; m_q.delete();
        end else if (!m_fault) begin
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) m_fault = 1;
            end else begin
                popped = (m_q.size() != 0) && insn_ready;
                slot   = (m_q.size() < 2) || popped;
                if (slot && !legal(m_pc)) begin
                    m_fault = 1;
                    m_q.delete();
                end else begin
                    if (popped) void'(m_q.pop_front());
                    if (slot) begin
                        m_q.push_back({mem_word(m_pc), m_pc});
                        m_pc    = m_pc + 32'd4;
                        m_cnt   = m_cnt + 32'd1;
                        m_clean = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("address", address, m_pc);
        check_eq("fault", 32'(fault), 32'(m_fault));
        check_eq("insn_valid", 32'(insn_valid), 32'(m_q.size() != 0));
        check_eq("fetch_count", fetch_count, m_cnt);
        check_eq("data_in", data_in, 32'd0);
        check_eq("read_write", 32'(read_write), 32'd0);
        if (m_q.size() != 0) begin
            check_eq("insn", insn, m_q[0][63:32]);
            check_eq("insn_pc", insn_pc, m_q[0][31:0]);
        end else if (m_clean) begin
            check_eq("insn_rst", insn, 32'd0);
            check_eq("insn_pc_rst", insn_pc, 32'd0);
        end
    endtask

    task automatic tick(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        insn_ready     = rdy;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        logic [31:0] rpc;
        int          sel;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
        m_pc = START; m_cnt = 0; m_fault = 0; m_clean = 1;
        @(negedge clock);

        // Streaming with consumer always ready
        tick(1, 0, 0, 0);
        check_eq("rst_address", address, 32'h0100_0000);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            check_eq("stream_pc", insn_pc, 32'h0100_0000 + 32'(4 * i));
        end
        check_eq("stream_cnt", fetch_count, 32'd4);

        // Back-pressure fills the buffer and stalls fetch
        tick(1, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 0);
        check_eq("stall_cnt", fetch_count, 32'd2);
        check_eq("stall_pc", insn_pc, 32'h0100_0000);
        check_eq("stall_addr", address, 32'h0100_0008);

        // Redirect with a full buffer
        tick(0, 1, 32'h0100_0100, 0);
        check_eq("redir_valid", 32'(insn_valid), 32'd0);
        tick(0, 0, 0, 0);
        check_eq("redir_valid2", 32'(insn_valid), 32'd1);
        check_eq("redir_pc", insn_pc, 32'h0100_0100);

        // Misaligned redirect faults; later redirects are ignored
        tick(0, 1, 32'h0100_0102, 1);
        check_eq("mis_fault", 32'(fault), 32'd1);
        check_eq("mis_valid", 32'(insn_valid), 32'd0);
        tick(0, 1, 32'h0100_0200, 1);
        check_eq("mis_fault2", 32'(fault), 32'd1);
        check_eq("mis_addr", address, 32'h0100_0102);
        tick(0, 0, 0, 1);
        check_eq("mis_valid2", 32'(insn_valid), 32'd0);

        // Last legal word is delivered, the next pc faults
        tick(1, 0, 0, 0);
        tick(0, 1, 32'h010F_FFFC, 1);
        tick(0, 0, 0, 1);
        check_eq("end_valid", 32'(insn_valid), 32'd1);
        check_eq("end_pc", insn_pc, 32'h010F_FFFC);
        tick(0, 0, 0, 1);
        check_eq("end_fault", 32'(fault), 32'd1);
        check_eq("end_valid2", 32'(insn_valid), 32'd0);
        tick(0, 0, 0, 1);
        check_eq("end_cnt", fetch_count, 32'd1);

        // Reset with a full buffer and a concurrent redirect
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 1, 32'h0100_0100, 1);
        check_eq("rst2_valid", 32'(insn_valid), 32'd0);
        check_eq("rst2_insn", insn, 32'd0);
        check_eq("rst2_pc", insn_pc, 32'd0);
        check_eq("rst2_cnt", fetch_count, 32'd0);
        check_eq("rst2_addr", address, 32'h0100_0000);
        tick(0, 0, 0, 0);
        check_eq("rst2_first", insn_pc, 32'h0100_0000);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       rpc = START + 32'($urandom_range(0, 255));
                1, 2:    rpc = START + DEPTH - 32'd4 - 32'(4 * $urandom_range(0, 3));
                3:       rpc = START - 32'd4;
                default: rpc = START + 32'(4 * $urandom_range(0, 63));
            endcase
            tick(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) == 0), rpc,
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
